seven_segment_display_mux: RTL and testbench

//   Parametrised successor to the 8-digit seven-segment interface: drives N multiplexed digits directly
//   (anode scan + segment decode) instead of exporting a raw digit bus. Shows selected channel colour
//   (hex), the last valid frame number (decimal, via sequential binary-to-BCD), or a blinking fault screen.

---
 rtl/seven_seg_pkg.sv | 79 +++++++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/seven_segment_display_mux.sv | 236 +++++++++++++++++++++++
 tb/tb_seven_segment_display_mux.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display: glyphs,
// display modes, converter states and small helper functions.
package seven_seg_pkg;

    // Display content selected by the mode controller.
    typedef enum logic [1:0] {
        MODE_COLOR = 2'd0,
        MODE_FRAME = 2'd1,
        MODE_FAULT = 2'd2
    } mode_e;

    // Binary-to-BCD converter state.
    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_T     = 7'h07;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex nibble to active-low segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

    // Decimal digits needed for the largest value of a w-bit number.
    function automatic int bcd_digits_for(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                n++;
                v = v / 10;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// A start while running reloads the new value; the result is presented
// combinationally on bcd together with a one-cycle done on the final step.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int BIN_W      = 9,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        din,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * BCD_DIGITS;

    conv_state_e       state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] work;
    logic                   last_step;

    // One double-dabble step: add 3 to any digit >= 5, then shift left.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
        work = {acc_adj, bin_q} << 1;
    end

    assign last_step = (state_q == CONV_RUN) && (cnt_q == CNT_W'(1)) && !start;
    assign busy      = (state_q == CONV_RUN);
    assign done      = last_step;
    assign bcd       = work[ACC_W+BIN_W-1 -: ACC_W];

    // Converter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start (re)loads, otherwise step until the bit count runs out.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = CONV_RUN;
            bin_d   = din;
            acc_d   = '0;
            cnt_d   = CNT_W'(BIN_W);
        end else if (state_q == CONV_RUN) begin
            bin_d = work[BIN_W-1:0];
            acc_d = work[ACC_W+BIN_W-1 -: ACC_W];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = CONV_IDLE;
            end
        end
    end

endmodule

// File: rtl/seven_segment_display_mux.sv
// Multiplexed N-digit seven-segment driver: scans anodes, decodes colour
// (hex), frame number (decimal) or a blinking fault screen. Display content
// is snapshotted once per scan pass so a pass never mixes two states.
module seven_segment_display_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int COLOR_W      = 24,
    parameter int FRAME_W      = 9,
    parameter int SCAN_DIV     = 50000,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_7s_frame,
    input  logic                              debug_color,
    input  logic                              fault,
    input  logic                              frame_valid,
    input  logic [FRAME_W-1:0]                frame,
    input  logic [$clog2(NUM_CHANNELS)-1:0]   channel,
    input  logic [NUM_CHANNELS*COLOR_W-1:0]   rgb_flat,
    output logic [6:0]                        seg_n,
    output logic                              dp_n,
    output logic [NUM_DIGITS-1:0]             an_n,
    output logic                              busy
);

    localparam int BCD_DIGITS = bcd_digits_for(FRAME_W);
    localparam int NIB        = COLOR_W / 4;
    localparam int CH_W       = $clog2(NUM_CHANNELS);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W      = $clog2(SCAN_DIV);
    localparam int HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Scan timing
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               started_q, started_d;
    logic               tick, snap_en;
    logic [31:0]        idx_ext;

    // Mode controller
    mode_e              mode_q, mode_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Converted frame number and per-pass snapshot
    logic [4*BCD_DIGITS-1:0] bcd_q, conv_bcd;
    logic                    conv_done;
    mode_e                   snap_mode_q;
    logic [CH_W-1:0]         snap_chan_q;
    logic [COLOR_W-1:0]      snap_rgb_q;
    logic [4*BCD_DIGITS-1:0] snap_bcd_q;

    // Registered pin drivers
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    bin2bcd_seq #(
        .BIN_W      (FRAME_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (frame_valid),
        .din   (frame),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign tick    = (pre_q == PRE_W'(SCAN_DIV - 1));
    assign idx_ext = 32'(idx_q);

    // Prescaler and digit index; the first tick enables digit 0 and snapshots.
    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        started_d = started_q;
        snap_en   = 1'b0;
        if (tick) begin
            if (!started_q) begin
                started_d = 1'b1;
                snap_en   = 1'b1;
            end else if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d   = '0;
                snap_en = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Mode FSM next state; fault overrides everything including en_7s_frame.
    always_comb begin
        mode_d = mode_q;
        hold_d = hold_q;
        case (mode_q)
            MODE_COLOR: begin
                if (en_7s_frame) begin
                    mode_d = MODE_FRAME;
                    hold_d = HOLD_W'(HOLD_CYCLES);
                end
            end
            MODE_FRAME: begin
                if (en_7s_frame) begin
                    hold_d = HOLD_W'(HOLD_CYCLES);
                end else if (hold_q == HOLD_W'(1)) begin
                    mode_d = MODE_COLOR;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            MODE_FAULT: begin
                if (!fault) begin
                    mode_d = MODE_COLOR;
                end
            end
            default: mode_d = MODE_COLOR;
        endcase
        if (fault) begin
            mode_d = MODE_FAULT;
            hold_d = '0;
        end
    end

    // Blink counter: cleared on fault entry, free-runs while in fault.
    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (mode_q == MODE_FAULT && mode_d == MODE_FAULT) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = !blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_off_d = blink_off_q;
            end
        end
    end

    // Glyph for the current digit from the snapshot; also anode pattern.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (snap_mode_q)
            MODE_COLOR: begin
                for (int p = 0; p < NIB; p++) begin
                    if (idx_ext == 32'(p)) seg_d = hex_to_seg(snap_rgb_q[p*4 +: 4]);
                end
                if (idx_ext == 32'(NIB)) begin
                    seg_d = hex_to_seg(4'(snap_chan_q));
                    dp_d  = 1'b0;
                end
                if (idx_ext == 32'(NIB + 1)) seg_d = SEG_C;
            end
            MODE_FRAME: begin
                for (int p = 0; p < BCD_DIGITS; p++) begin
                    if (idx_ext == 32'(p) && (p == 0 || (snap_bcd_q >> (4 * p)) != '0)) begin
                        seg_d = hex_to_seg(snap_bcd_q[p*4 +: 4]);
                    end
                end
                if (idx_ext == 32'(NUM_DIGITS - 1)) seg_d = SEG_F;
            end
            MODE_FAULT: begin
                if (idx_ext == 32'(NUM_DIGITS - 1)) seg_d = SEG_F;
                if (idx_ext == 32'(NUM_DIGITS - 2)) seg_d = SEG_A;
                if (idx_ext == 32'(NUM_DIGITS - 3)) seg_d = SEG_U;
                if (idx_ext == 32'(NUM_DIGITS - 4)) seg_d = SEG_L;
                if (idx_ext == 32'(NUM_DIGITS - 5)) seg_d = SEG_T;
            end
            default: seg_d = SEG_BLANK;
        endcase
        if (!started_q) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
        if (!started_q || (mode_q == MODE_FAULT && blink_off_q)) begin
            an_d = '1;
        end else begin
            an_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
        end
    end

    // State registers: scan, mode, blink, snapshot, converted value, pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q       <= '0;
            idx_q       <= '0;
            started_q   <= 1'b0;
            mode_q      <= MODE_COLOR;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            bcd_q       <= '0;
            snap_mode_q <= MODE_COLOR;
            snap_chan_q <= '0;
            snap_rgb_q  <= '0;
            snap_bcd_q  <= '0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            started_q   <= started_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            if (conv_done) begin
                bcd_q <= conv_bcd;
            end
            if (snap_en) begin
                snap_mode_q <= (debug_color || mode_q == MODE_COLOR) ? MODE_COLOR : mode_q;
                snap_chan_q <= channel;
                snap_rgb_q  <= rgb_flat[channel*COLOR_W +: COLOR_W];
                snap_bcd_q  <= bcd_q;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign dp_n  = dp_q;
    assign an_n  = an_q;

endmodule

// File: tb/tb_seven_segment_display_mux.sv
// Bench for seven_segment_display_mux: expected digit passes are queued when
// a screen is set up and compared slot by slot as the display scans them.
module tb_seven_segment_display_mux;

    localparam int ND = 8;
    localparam int NC = 4;
    localparam int CW = 24;
    localparam int FW = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_7s_frame, debug_color, fault, frame_valid;
    logic [FW-1:0]    frame;
    logic [1:0]       channel;
    logic [NC*CW-1:0] rgb_flat;
    logic [6:0]       seg_n;
    logic             dp_n;
    logic [ND-1:0]    an_n;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // {may_blank, an[7:0], seg[6:0], dp}
    logic [16:0] exp_q[$];

    seven_segment_display_mux #(
        .NUM_DIGITS   (ND),
        .NUM_CHANNELS (NC),
        .COLOR_W      (CW),
        .FRAME_W      (FW),
        .SCAN_DIV     (4),
        .HOLD_CYCLES  (400),
        .BLINK_DIV    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_7s_frame (en_7s_frame),
        .debug_color (debug_color),
        .fault       (fault),
        .frame_valid (frame_valid),
        .frame       (frame),
        .channel     (channel),
        .rgb_flat    (rgb_flat),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .busy        (busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [6:0] G_C   = ~7'h39;
    localparam logic [6:0] G_F   = ~7'h71;
    localparam logic [6:0] G_A   = ~7'h77;
    localparam logic [6:0] G_U   = ~7'h3E;
    localparam logic [6:0] G_L   = ~7'h38;
    localparam logic [6:0] G_T   = ~7'h78;
    localparam logic [6:0] G_BLK = 7'h7F;

    // active-high {g..a} digit shapes, inverted for the pins
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] hi;
        case (v)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_digit(input int d, input logic [6:0] seg, input logic dp, input logic mb);
        logic [7:0] an;
        an = ~(8'd1 << d);
        exp_q.push_back({mb, an, seg, dp});
    endtask

    task automatic push_color(input int ch, input logic [23:0] rgb, input logic mb);
        for (int d = 0; d < ND; d++) begin
            if (d < 6)       push_digit(d, glyph(rgb[d*4 +: 4]), 1'b1, mb);
            else if (d == 6) push_digit(d, glyph(4'(ch)), 1'b0, mb);
            else             push_digit(d, G_C, 1'b1, mb);
        end
    endtask

    task automatic push_frame(input int val);
        int v;
        logic [3:0] dig[3];
        v = val;
        for (int i = 0; i < 3; i++) begin
            dig[i] = 4'(v % 10);
            v = v / 10;
        end
        for (int d = 0; d < ND; d++) begin
            if (d == 7)                  push_digit(d, G_F, 1'b1, 1'b0);
            else if (d == 0)             push_digit(d, glyph(dig[0]), 1'b1, 1'b0);
            else if (d == 1 && val >= 10)  push_digit(d, glyph(dig[1]), 1'b1, 1'b0);
            else if (d == 2 && val >= 100) push_digit(d, glyph(dig[2]), 1'b1, 1'b0);
            else                         push_digit(d, G_BLK, 1'b1, 1'b0);
        end
    endtask

    task automatic push_fault();
        logic [6:0] g[8];
        g[7] = G_F; g[6] = G_A; g[5] = G_U; g[4] = G_L; g[3] = G_T;
        g[2] = G_BLK; g[1] = G_BLK; g[0] = G_BLK;
        for (int d = 0; d < ND; d++) push_digit(d, g[d], 1'b1, 1'b1);
    endtask

    // wait for a fresh scan pass, then compare each slot against the queue
    task automatic check_pass(input string tag);
        logic [7:0] prev;
        logic [16:0] e;
        bit found;
        repeat (2) @(negedge clk);
        prev  = an_n;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (an_n == 8'hFE && prev != 8'hFE) found = 1;
            prev = an_n;
        end
        if (!found) begin
            check({tag, "_pass_start"}, 0, 1);
            exp_q.delete();
            return;
        end
        for (int d = 0; d < ND; d++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue"}, 0, 1);
                return;
            end
            e = exp_q.pop_front();
            if (!(e[16] && an_n == 8'hFF)) begin
                check($sformatf("%s_an%0d", tag, d), 32'(an_n), 32'(e[15:8]));
                check($sformatf("%s_seg%0d", tag, d), 32'(seg_n), 32'(e[7:1]));
                check($sformatf("%s_dp%0d", tag, d), 32'(dp_n), 32'(e[0]));
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse_en();
        en_7s_frame = 1'b1;
        @(negedge clk);
        en_7s_frame = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic convert(input int v, output int n);
        frame       = FW'(v);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        count_busy(n);
    endtask

    task automatic count_off(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (an_n == 8'hFF) n++;
        end
    endtask

    function automatic logic [23:0] word(input int ch);
        return rgb_flat[ch*CW +: CW];
    endfunction

    initial begin
        int n;
        int t_en;
        int ch;
        logic [7:0] exp_an;

        rst = 1'b0; en_7s_frame = 1'b0; debug_color = 1'b0; fault = 1'b0;
        frame_valid = 1'b0; frame = '0; channel = 2'd0;
        rgb_flat = {24'hFFFF00, 24'hABCDEF, 24'h9A0C51, 24'h123456};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an_n), 32'hFF);
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_dp", 32'(dp_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // anode scan order from release
        n = 0;
        while (an_n == 8'hFF && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scan_first", 32'(an_n), 32'hFE);
        for (int k = 1; k <= 8; k++) begin
            repeat (4) @(negedge clk);
            exp_an = ~(8'd1 << (k % 8));
            check($sformatf("scan_%0d", k), 32'(an_n), 32'(exp_an));
        end

        // colour screens
        push_color(0, word(0), 1'b0);
        check_pass("col_ch0");
        channel = 2'd3;
        push_color(3, word(3), 1'b0);
        check_pass("col_ch3");
        for (int r = 0; r < 2; r++) begin
            ch = $urandom_range(0, 3);
            rgb_flat[ch*CW +: CW] = 24'($urandom);
            channel = 2'(ch);
            push_color(ch, word(ch), 1'b0);
            check_pass("col_rand");
        end

        // frame screen, debug override, hold expiry
        convert(153, n);
        check("busy_153", n, 9);
        pulse_en();
        t_en = cyc;
        push_frame(153);
        check_pass("frm_153");
        debug_color = 1'b1;
        push_color(ch, word(ch), 1'b0);
        check_pass("frm_dbg");
        debug_color = 1'b0;
        push_frame(153);
        check_pass("frm_153b");
        while (cyc < t_en + 330) @(negedge clk);
        push_frame(153);
        check_pass("frm_late");
        while (cyc < t_en + 404) @(negedge clk);
        push_color(ch, word(ch), 1'b0);
        check_pass("hold_expired");

        // restart: latest frame_valid wins
        frame = 9'd153;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        frame = 9'd511;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        count_busy(n);
        check("busy_restart", n, 9);
        pulse_en();
        push_frame(511);
        check_pass("frm_511");
        convert(7, n);
        check("busy_7", n, 9);
        push_frame(7);
        check_pass("frm_7");
        convert(0, n);
        push_frame(0);
        check_pass("frm_0");

        // fault: beats en_7s_frame, blinks, debug colour, release
        fault = 1'b1;
        pulse_en();
        count_off(60, n);
        check("fault_on_half", n, 0);
        push_fault();
        check_pass("fault");
        count_off(256, n);
        check("fault_blink", n, 128);
        debug_color = 1'b1;
        push_color(ch, word(ch), 1'b1);
        check_pass("fault_dbg");
        debug_color = 1'b0;
        fault = 1'b0;
        push_color(ch, word(ch), 1'b0);
        check_pass("fault_clear");
        count_off(128, n);
        check("steady_after_fault", n, 0);

        // reset during frame hold with a conversion running
        pulse_en();
        frame = 9'd300;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_an", 32'(an_n), 32'hFF);
        check("mid_rst_seg", 32'(seg_n), 32'h7F);
        check("mid_rst_dp", 32'(dp_n), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_color(ch, word(ch), 1'b0);
        check_pass("post_rst_col");
        pulse_en();
        push_frame(0);
        check_pass("post_rst_bcd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time guard
    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
